mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 114 +++++++++++
 1 files changed

// File: rtl/mdu.sv
// mdu: RV32M multiply/divide unit, 32-iteration shift-add multiply and restoring divide.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle 33x33 multiplier.
package riscv_defines;
   localparam int MDU_OP_WIDTH = 3;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'd0;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'd1;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'd2;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'd3;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'd4;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'd5;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'd6;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'd7;
endpackage

module mdu
   import riscv_defines::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic [MDU_OP_WIDTH-1:0] mdu_op_i,
   input  logic [WIDTH-1:0]        op_a_i,
   input  logic [WIDTH-1:0]        op_b_i,
   input  logic                    kill_i,
   output logic                    busy_o,
   output logic                    valid_o,
   output logic [WIDTH-1:0]        result_o
);
   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
   state_t state, state_nxt;
   logic [MDU_OP_WIDTH-1:0] op;
   logic sign_a, sign_b;
   logic [WIDTH-1:0] acc, lo, b_reg;
   logic [5:0] cnt;
   logic sgn_a_in, sgn_b_in, div_zero, div_ovf, fast, accept, last, borrow;
   logic [WIDTH-1:0] abs_a, abs_b, spec_res, fast_res, acc_n, lo_n, q_s, r_s, fin_res;
   logic [WIDTH:0] mul_sum, shifted, diff;
   logic [2*WIDTH-1:0] prod_s;

   assign sgn_a_in = op_a_i[WIDTH-1] & (mdu_op_i inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM});
   assign sgn_b_in = op_b_i[WIDTH-1] & (mdu_op_i inside {MDU_MULH, MDU_DIV, MDU_REM});
   assign abs_a = sgn_a_in ? -op_a_i : op_a_i;
   assign abs_b = sgn_b_in ? -op_b_i : op_b_i;
   assign div_zero = mdu_op_i[2] && op_b_i == '0;
   assign div_ovf = (mdu_op_i inside {MDU_DIV, MDU_REM}) && op_a_i == {1'b1, {(WIDTH-1){1'b0}}} && op_b_i == '1;
   assign spec_res = div_zero ? (mdu_op_i[1] ? op_a_i : '1) : (mdu_op_i[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}});

`ifdef MDU_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_p;
   assign fast_p = (2*WIDTH)'($signed({sgn_a_in, op_a_i}) * $signed({sgn_b_in, op_b_i}));
   assign fast = ~mdu_op_i[2];
   assign fast_res = mdu_op_i == MDU_MUL ? fast_p[WIDTH-1:0] : fast_p[2*WIDTH-1:WIDTH];
`else
   assign fast = 1'b0;
   assign fast_res = '0;
`endif

   // lo holds the multiplier (MUL*) or the dividend/quotient (DIV*); acc is the high product or remainder
   assign mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, b_reg} : '0);
   assign shifted = {acc, lo[WIDTH-1]};
   assign diff = shifted - {1'b0, b_reg};
   assign borrow = diff[WIDTH];
   assign acc_n = op[2] ? (borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]) : mul_sum[WIDTH:1];
   assign lo_n = op[2] ? {lo[WIDTH-2:0], ~borrow} : {mul_sum[0], lo[WIDTH-1:1]};
   assign prod_s = (sign_a ^ sign_b) ? -{acc_n, lo_n} : {acc_n, lo_n};
   assign q_s = (sign_a ^ sign_b) ? -lo_n : lo_n;
   assign r_s = sign_a ? -acc_n : acc_n;
   assign fin_res = op[2] ? (op[1] ? r_s : q_s) : (op == MDU_MUL ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH]);
   assign accept = state == IDLE && start_i && !kill_i;
   assign last = cnt == 6'd31;

   always_ff @(posedge clk_i)
      state <= rst_i ? IDLE : state_nxt;

   always_comb begin
      state_nxt = state;
      busy_o = state != IDLE;
      valid_o = state == FIN;
      if (kill_i) state_nxt = IDLE;
      else if (accept) state_nxt = (div_zero || div_ovf || fast) ? FIN : CALC;
      else if (state == CALC && last) state_nxt = FIN;
      else if (state == FIN) state_nxt = IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         op <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         acc <= '0;
         lo <= '0;
         b_reg <= '0;
         cnt <= '0;
         result_o <= '0;
      end else if (accept) begin
         op <= mdu_op_i;
         sign_a <= sgn_a_in;
         sign_b <= sgn_b_in;
         acc <= '0;
         lo <= mdu_op_i[2] ? abs_a : abs_b;
         b_reg <= mdu_op_i[2] ? abs_b : abs_a;
         cnt <= '0;
         if (div_zero || div_ovf) result_o <= spec_res;
         else if (fast) result_o <= fast_res;
      end else if (!kill_i && state == CALC) begin
         acc <= acc_n;
         lo <= lo_n;
         cnt <= cnt + 6'd1;
         if (last) result_o <= fin_res;
      end
   end
endmodule
